mdu_controller: RTL
===================

MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 Parameter: MUL_CYCLES, default 5, multiply latency in cycles, legal range 1..16.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  reset; synchronous, active-high; clock is clock.
REQ-004 Port: start  input  1  EX-stage MDU request valid this cycle.
REQ-005 Port: op  input  3  request type: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-006 Port: operand1  input  32  rs value: dividend, multiplicand, or MT source.
REQ-007 Port: operand2  input  32  rt value: divisor or multiplier.
REQ-008 Port: stall  output  1  combinational; EX must hold this request.
REQ-009 Port: busy  output  1  registered; multiply or divide in flight.
REQ-010 Port: result  output  32  combinational MF read data.
REQ-011 Port: hi  output  32  architectural HI register.
REQ-012 Port: lo  output  32  architectural LO register.

Function
REQ-013 FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX; busy is 1 in every state except IDLE.
REQ-014 stall = start && busy, for any op; a stalled request has no effect and is re-presented by EX.
REQ-015 A request is accepted on an edge with start=1 and busy=0; EX presents each instruction for exactly one unstalled cycle.
REQ-016 MULT/MULTU accepted at edge N: latch operands, go to MUL_RUN, load counter; {hi,lo} written with the 64-bit product at edge N+MUL_CYCLES; return to IDLE on that same edge.
REQ-017 MULT is signed 32x32->64; MULTU is unsigned.
REQ-018 DIV/DIVU accepted at edge N: latch magnitudes and sign flags, go to DIV_RUN.
REQ-019 DIV_RUN is a restoring divider producing one quotient bit per edge, MSB first, for 32 edges; then DIV_FIX for one edge.
REQ-020 DIV_FIX applies signs and writes hi/lo at edge N+33, then returns to IDLE.
REQ-021 Divide results: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend for DIV.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0 (wrap, no trap).
REQ-023 Divide by zero, DIV and DIVU: lo = 0xFFFFFFFF and hi = operand1.
REQ-024 MTHI/MTLO accepted at edge N write operand1 to hi/lo at edge N; state stays IDLE.
REQ-025 MFHI/MFLO: result = hi/lo combinationally when busy=0; result is 0 when start=0 or op<6.
REQ-026 An MF request in the same cycle that busy falls sees the value written on the preceding edge.
REQ-027 hi/lo do not change during MUL_RUN/DIV_RUN until the completing edge.

Reset
REQ-028 reset=1 at an edge forces IDLE and hi=lo=0, clears counter and divider state, and aborts any in-flight operation with no hi/lo write.
REQ-029 During reset and on the first cycle after it: busy=0, stall=0, result=0.
REQ-030 reset has priority over acceptance on the same edge.

Configuration
REQ-031 Macro MDU_DIV_ZERO_FAST_EN defined: DIV/DIVU with operand2=0 skips DIV_RUN, writes REQ-023 values at edge N+1, and busy is high for 1 cycle.
REQ-032 Macro MDU_DIV_ZERO_FAST_EN undefined: divide by zero takes the full 33-cycle path with identical final hi/lo values.

Verification
REQ-033 MULT 0xFFFFFFFE x 3 at edge N, MUL_CYCLES=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA at edge N+5; MFLO issued at N+1 stalls 4 cycles, then result=0xFFFFFFFA.
REQ-034 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at edge N+33; DIVU 7/2 -> lo=3, hi=1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, at N+1 with the macro and N+33 without.
REQ-036 MTHI 0x12345678 then MFHI the next cycle -> result=0x12345678 with no stall; MULTU issued while busy -> stall=1 until busy falls, then accepted once.
REQ-037 reset asserted at edge N+10 of a DIV -> hi=lo=0, busy=0 from edge N+10, and no later hi/lo write.

Source files
------------

// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// Module      : mdu_controller
// Description : HI/LO multiply-divide unit controller for a MIPS-style EX
//               stage. Multi-cycle MULT/MULTU (MUL_CYCLES latency) and a
//               32-step restoring DIV/DIVU followed by one sign-fix cycle.
//               MTHI/MTLO write in a single cycle; MFHI/MFLO read
//               combinationally. Requests that arrive while busy are stalled.
// Ports       : clock    - rising-edge clock
//               reset    - synchronous, active-high reset
//               start    - EX-stage request valid
//               op       - 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MFHI 7 MFLO
//               operand1 - rs: dividend / multiplicand / MT source
//               operand2 - rt: divisor / multiplier
//               stall    - EX must hold the current request
//               busy     - multiply or divide in flight (registered)
//               result   - MFHI/MFLO read data
//               hi, lo   - architectural HI/LO registers
// Options     : MDU_DIV_ZERO_FAST_EN - when defined, divide by zero finishes
//               one cycle after acceptance instead of running the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_controller #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MUL_RUN = 2'd1;
    localparam logic [1:0] c_ST_DIV_RUN = 2'd2;
    localparam logic [1:0] c_ST_DIV_FIX = 2'd3;

    localparam logic [5:0] c_MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD = 6'd31;

    logic [1:0]  r_state;
    logic        r_busy;
    logic [5:0]  r_count;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic        r_mulSigned;
    logic        r_negQ;
    logic        r_negR;
    logic        r_divZero;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signedDiv;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [63:0] w_extA;
    logic [63:0] w_extB;
    logic [63:0] w_product;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_remNext;
    logic [31:0] w_quotNext;
    logic [31:0] w_fixHi;
    logic [31:0] w_fixLo;
    logic        w_mfRead;

    // Magnitudes for the divider; 0x80000000 negates to itself, which is
    // the correct unsigned magnitude.
    assign w_signedDiv = (op == c_OP_DIV);
    assign w_absA = (w_signedDiv && operand1[31]) ? (32'd0 - operand1) : operand1;
    assign w_absB = (w_signedDiv && operand2[31]) ? (32'd0 - operand2) : operand2;

    // The low 64 bits of a 64x64 product of sign/zero-extended operands are
    // the exact signed or unsigned 32x32 product.
    assign w_extA    = {{32{r_mulSigned & r_opA[31]}}, r_opA};
    assign w_extB    = {{32{r_mulSigned & r_opB[31]}}, r_opB};
    assign w_product = w_extA * w_extB;

    // Restoring step: the partial remainder is always below the divisor, so
    // the shifted value fits in 33 bits and bit 32 of the difference is the
    // borrow.
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = ~w_diff[32];
    assign w_remNext  = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quotNext = {r_quot[30:0], w_ge};

    // Divide by zero overrides the divider output in both build variants.
    assign w_fixLo = r_divZero ? 32'hFFFF_FFFF : (r_negQ ? (32'd0 - r_quot) : r_quot);
    assign w_fixHi = r_divZero ? r_opA         : (r_negR ? (32'd0 - r_rem)  : r_rem);

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall    = start && r_busy && !reset;
    assign w_mfRead = start && !r_busy && !reset && (op[2:1] == 2'b11);
    assign result   = w_mfRead ? (op[0] ? r_lo : r_hi) : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_count     <= 6'd0;
            r_opA       <= 32'd0;
            r_opB       <= 32'd0;
            r_mulSigned <= 1'b0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_divZero   <= 1'b0;
            r_rem       <= 32'd0;
            r_quot      <= 32'd0;
            r_divisor   <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_opA       <= operand1;
                                r_opB       <= operand2;
                                r_mulSigned <= (op == c_OP_MULT);
                                r_count     <= c_MUL_LOAD;
                                r_state     <= c_ST_MUL_RUN;
                                r_busy      <= 1'b1;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_opA     <= operand1;
                                r_opB     <= operand2;
                                r_rem     <= 32'd0;
                                r_quot    <= w_absA;
                                r_divisor <= w_absB;
                                r_negQ    <= w_signedDiv & (operand1[31] ^ operand2[31]);
                                r_negR    <= w_signedDiv & operand1[31];
                                r_divZero <= (operand2 == 32'd0);
                                r_count   <= c_DIV_LOAD;
                                r_busy    <= 1'b1;
`ifdef MDU_DIV_ZERO_FAST_EN
                                r_state   <= (operand2 == 32'd0) ? c_ST_DIV_FIX : c_ST_DIV_RUN;
`else
                                r_state   <= c_ST_DIV_RUN;
`endif
                            end
                            c_OP_MTHI: r_hi <= operand1;
                            c_OP_MTLO: r_lo <= operand1;
                            default: ;  // MFHI/MFLO only read
                        endcase
                    end
                end
                c_ST_MUL_RUN: begin
                    if (r_count == 6'd0) begin
                        r_hi    <= w_product[63:32];
                        r_lo    <= w_product[31:0];
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 6'd1;
                    end
                end
                c_ST_DIV_RUN: begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                    if (r_count == 6'd0) begin
                        r_state <= c_ST_DIV_FIX;
                    end else begin
                        r_count <= r_count - 6'd1;
                    end
                end
                default: begin  // c_ST_DIV_FIX
                    r_hi    <= w_fixHi;
                    r_lo    <= w_fixLo;
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
